wb_arb_m: RTL

WB_ARB_M -- requirements
Module: wb_arb_m

---
 rtl/wb_arb_m.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_arb_m.sv
// rtl/wb_arb_m.sv - register-file writeback arbiter: ALU vs buffered memory results, with a pending-write scoreboard
module wb_arb_m #(
  parameter int REGW   = 32,
  parameter int MSB    = 4,
  parameter int STARVE = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    alu_valid,
  input  logic [MSB:0]            alu_rd,
  input  logic [REGW-1:0]         alu_data,
  output logic                    alu_ready,
  input  logic                    mem_valid,
  input  logic [MSB:0]            mem_rd,
  input  logic [REGW-1:0]         mem_data,
  output logic                    mem_ready,
  input  logic                    iss_valid,
  input  logic [MSB:0]            iss_rd,
  output logic                    we3,
  output logic [MSB:0]            a3,
  output logic [REGW-1:0]         wd3,
  output logic [2**(MSB+1)-1:0]   busy
);

  localparam int NR = 2 ** (MSB + 1);
  localparam int CW = (STARVE > 1) ? $clog2(STARVE) : 1;

  logic [MSB:0]    frd_q   [2];
  logic [REGW-1:0] fdata_q [2];
  logic            head_q;
  logic [1:0]      cnt_q, cnt_d;
  logic            mem_ready_q;
  logic [CW-1:0]   stv_q, stv_d;
  logic [NR-1:0]   busy_q, busy_d;
  logic            we3_q;
  logic [MSB:0]    a3_q;
  logic [REGW-1:0] wd3_q;

  logic            fifo_ne, stv_max, alu_win, pop, push, win_any, tail;
  logic [MSB:0]    win_rd;
  logic [REGW-1:0] win_data;

  // The ALU is only held off once a queued memory result has been passed over STARVE-1 times.
  assign fifo_ne   = (cnt_q != 2'd0);
  assign stv_max   = (stv_q == CW'(STARVE - 1));
  assign alu_ready = !(stv_max && fifo_ne);
  assign alu_win   = alu_valid && alu_ready;
  assign pop       = !alu_win && fifo_ne;
  assign push      = mem_valid && mem_ready_q;
  assign win_any   = alu_win || pop;
  assign win_rd    = alu_win ? alu_rd   : frd_q[head_q];
  assign win_data  = alu_win ? alu_data : fdata_q[head_q];
  assign tail      = head_q ^ cnt_q[0];
  assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    stv_d = stv_q;
    if (pop)
      stv_d = '0;
    else if (fifo_ne && alu_win && !stv_max)
      stv_d = stv_q + CW'(1);
  end

  // An issue reservation beats a same-edge writeback to the same register.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NR; r++) begin
      busy_d[r] = (busy_q[r] && !(win_any && win_rd == r[MSB:0])) ||
                  (iss_valid && iss_rd == r[MSB:0]);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frd_q       <= '{default: '0};
      fdata_q     <= '{default: '0};
      head_q      <= 1'b0;
      cnt_q       <= 2'd0;
      mem_ready_q <= 1'b0;
      stv_q       <= '0;
      busy_q      <= '0;
      we3_q       <= 1'b0;
      a3_q        <= '0;
      wd3_q       <= '0;
    end else begin
      if (push) begin
        frd_q[tail]   <= mem_rd;
        fdata_q[tail] <= mem_data;
      end
      if (pop)
        head_q <= ~head_q;
      cnt_q       <= cnt_d;
      mem_ready_q <= (cnt_d != 2'd2);
      stv_q       <= stv_d;
      busy_q      <= busy_d;
      we3_q       <= win_any && (win_rd != '0);
      if (win_any && win_rd != '0) begin
        a3_q  <= win_rd;
        wd3_q <= win_data;
      end
    end
  end

  assign mem_ready = mem_ready_q;
  assign busy      = busy_q;
  assign we3       = we3_q;
  assign a3        = a3_q;
  assign wd3       = wd3_q;

endmodule
